call_stack: RTL and testbench
=============================

// Module: call_stack
// PURPOSE
//  Hardware return-address stack for the 19-bit CPU. It executes the push/pop/ret
//  strobes that the control decoder emits for CALL and RET.
//  On CALL it saves the return PC. On RET it supplies the saved target to the PC
//  mux and discards it.
//  Sits beside the PC register in the fetch/decode stage. It also reports
//  overflow and underflow to the core as sticky error flags.
// PARAMETERS
//  ADDR_W  19  width of a stored return address (PC width)
//  DEPTH    8  number of stack entries; power of two, >= 2
//  PTR_W    3  log2(DEPTH); count is PTR_W+1 bits wide
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  push       in   1         CALL strobe from control
//  pop        in   1         RET strobe from control
//  stall      in   1         pipeline hazard/stall; when 1, push and pop are ignored
//  push_addr  in   ADDR_W    return address to save (PC+1 of the CALL)
//  err_clr    in   1         clears the sticky ovf/unf flags
//  ret_addr   out  ADDR_W    top-of-stack entry; valid when empty=0
//  empty      out  1         count==0
//  full       out  1         count==DEPTH
//  count      out  PTR_W+1   number of valid entries
//  ovf        out  1         sticky: a push was attempted while full
//  unf        out  1         sticky: a pop was attempted while empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): count=0, empty=1, full=0, ovf=0, unf=0, ret_addr=0.
//    All entries are cleared to 0.
//  - Reset mid-operation wins immediately. No stored entry survives reset.
//  - Storage: DEPTH x ADDR_W registers plus a stack pointer sp (PTR_W+1 bits).
//    sp equals count, so the top entry is mem[sp-1].
//  - ret_addr is a combinational read of mem[sp-1]: zero-latency for RET in the
//    same cycle. It is forced to 0 when empty.
//  - Effective strobes: do_push = push & ~stall; do_pop = pop & ~stall.
//    All updates take effect on the rising clk edge.
//  - do_push & ~do_pop:
//    - not full: mem[sp] <= push_addr; sp <= sp+1.
//    - full: no write, sp unchanged, ovf <= 1. Oldest entries are never overwritten.
//  - do_pop & ~do_push:
//    - not empty: sp <= sp-1. The entry is not cleared.
//    - empty: sp stays 0, unf <= 1.
//  - do_push & do_pop in the same cycle is a replace:
//    - not empty: mem[sp-1] <= push_addr, sp unchanged. ret_addr shows the old top
//      that cycle.
//    - empty: acts as a plain push, unf not set.
//    - No ovf in either case, even when full.
//  - err_clr: ovf <= 0, unf <= 0.
//    If an error event occurs in the same cycle, the set wins.
//  - count arithmetic is unsigned, with no wrap. Saturation at 0 and at DEPTH is
//    guaranteed by the guards above.
//  - No internal state machine beyond sp. States are {EMPTY, PARTIAL, FULL},
//    implied by count; outputs are derived from sp only.
// STRUCTURE
//  - parameter.v gains `define STACK_DEPTH 8 and `define PC_W 19. The
//    instantiating core passes these as DEPTH and ADDR_W.
//  - One natural sub-module: call_stack_mem.
//    - DEPTH x ADDR_W register file: one sync write port, one async read port,
//      async clear on rst_n.
//    - Pointer, guards and flags stay in call_stack.
// TESTING
//  1. Reset then 3 pushes (0x00010, 0x00020, 0x00030):
//     -> count=3, ret_addr=0x00030; 3 pops return 0x30, 0x20, 0x10; then empty=1.
//  2. Fill with 8 pushes, then push 0x7FFFF:
//     -> full=1, count=8, ovf=1, ret_addr unchanged (8th value).
//     err_clr -> ovf=0.
//  3. Pop on an empty stack:
//     -> unf=1, count=0, ret_addr=0.
//     err_clr and pop in the same cycle -> unf stays 1.
//  4. push=1 with stall=1 (address 0x00055):
//     -> no state change.
//     Same cycle with pop=1, stall=1 -> no pop, no flags.
//  5. Stack holds 0x11; push=pop=1 with push_addr=0x22:
//     -> ret_addr=0x11 that cycle; next cycle count=1, ret_addr=0x22.
//     Same on a full stack -> no ovf.
//  6. Assert rst_n=0 asynchronously between edges with count=5:
//     -> count=0, empty=1, ovf=unf=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/call_stack_pkg.sv
// rtl/call_stack_pkg.sv - shared types and defaults for the return-address stack
package call_stack_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } stack_state_e;

  // Occupancy class is implied by the entry count alone
  function automatic stack_state_e classify(input int cnt, input int depth);
    if (cnt == 0)
      return ST_EMPTY;
    else if (cnt >= depth)
      return ST_FULL;
    else
      return ST_PARTIAL;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// rtl/call_stack_if.sv - control-side strobes and stack status bundle
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PTR_W  = $clog2(DEF_DEPTH)
);

  logic              push;
  logic              pop;
  logic              stall;
  logic [ADDR_W-1:0] push_addr;
  logic              err_clr;
  logic [ADDR_W-1:0] ret_addr;
  logic              empty;
  logic              full;
  logic [PTR_W:0]    count;
  logic              ovf;
  logic              unf;

  modport master (
    output push, pop, stall, push_addr, err_clr,
    input  ret_addr, empty, full, count, ovf, unf
  );

  modport slave (
    input  push, pop, stall, push_addr, err_clr,
    output ret_addr, empty, full, count, ovf, unf
  );

endinterface

// File: rtl/call_stack_mem.sv
// rtl/call_stack_mem.sv - DEPTH x ADDR_W register file, one sync write, one async read
module call_stack_mem
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - hardware return-address stack for CALL/RET
// Stack pointer, push/pop guards and sticky error flags; storage in call_stack_mem.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  call_stack_if.slave   bus
);

  localparam logic [PTR_W:0] ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]    sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              do_push, do_pop;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top_data;
  stack_state_e      st;

  assign do_push = bus.push & ~bus.stall;
  assign do_pop  = bus.pop  & ~bus.stall;
  assign st      = classify(int'(sp_q), DEPTH);
  assign top_idx = PTR_W'(sp_q - ONE);

  call_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.push_addr),
    .raddr_i (top_idx),
    .rdata_o (top_data)
  );

  // Clear first so that an error event in the same cycle sets the flag again
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = PTR_W'(sp_q);
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    unique case ({do_push, do_pop})
      2'b10: begin
        if (st != ST_FULL) begin
          we   = 1'b1;
          sp_d = sp_q + ONE;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (st != ST_EMPTY)
          sp_d = sp_q - ONE;
        else
          unf_d = 1'b1;
      end
      2'b11: begin
        we = 1'b1;
        if (st == ST_EMPTY)
          sp_d = ONE;
        else
          waddr = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.count    = sp_q;
  assign bus.empty    = (st == ST_EMPTY);
  assign bus.full     = (st == ST_FULL);
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.ret_addr = (st == ST_EMPTY) ? '0 : top_data;

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - randomized self-checking bench for call_stack
module tb_call_stack;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  int unsigned stk[$];
  bit          m_ovf;
  bit          m_unf;

  call_stack_if #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) bus ();

  call_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned exp_ret;
    exp_ret = (stk.size() == 0) ? 0 : stk[$];
    chk({tag, ".count"}, 32'(bus.count), stk.size());
    chk({tag, ".ret_addr"}, 32'(bus.ret_addr), exp_ret);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(stk.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(stk.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.unf), 32'(m_unf));
  endtask

  // Reference behaviour: a LIFO queue with bounded size and sticky flags
  task automatic model_step(input bit p, input bit q, input bit s,
                            input int unsigned a, input bit c);
    bit dp, dq;
    dp = p && !s;
    dq = q && !s;
    if (c) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (dp && dq) begin
      if (stk.size() == 0) stk.push_back(a);
      else stk[stk.size()-1] = a;
    end else if (dp) begin
      if (stk.size() < DEPTH) stk.push_back(a);
      else m_ovf = 1;
    end else if (dq) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_unf = 1;
    end
  endtask

  task automatic cyc(input string tag, input bit p, input bit q, input bit s,
                     input int unsigned a, input bit c);
    bus.push      = p;
    bus.pop       = q;
    bus.stall     = s;
    bus.push_addr = a[ADDR_W-1:0];
    bus.err_clr   = c;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_step(p, q, s, a & 32'h7FFFF, c);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ovf   = 0;
    m_unf   = 0;
    rst_n   = 1'b0;
    bus.push = 0; bus.pop = 0; bus.stall = 0; bus.push_addr = '0; bus.err_clr = 0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three pushes then three pops
    cyc("t1_push", 1, 0, 0, 'h10, 0);
    cyc("t1_push", 1, 0, 0, 'h20, 0);
    cyc("t1_push", 1, 0, 0, 'h30, 0);
    chk("t1_top", 32'(bus.ret_addr), 'h30);
    for (int i = 0; i < 3; i++) cyc("t1_pop", 0, 1, 0, 0, 0);
    cyc("t1_idle", 0, 0, 0, 0, 0);

    // Fill, overflow, clear
    for (int i = 0; i < DEPTH; i++) cyc("t2_fill", 1, 0, 0, 'h100 + i, 0);
    cyc("t2_ovf", 1, 0, 0, 'h7FFFF, 0);
    chk("t2_ret_kept", 32'(bus.ret_addr), 'h107);
    cyc("t2_clr", 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc("t2_drain", 0, 1, 0, 0, 0);

    // Underflow, clear racing an underflow
    cyc("t3_unf", 0, 1, 0, 0, 0);
    cyc("t3_clr_pop", 0, 1, 0, 0, 1);
    cyc("t3_clr", 0, 0, 0, 0, 1);

    // Stall masks strobes
    cyc("t4_stall", 1, 0, 1, 'h55, 0);
    cyc("t4_stall2", 1, 1, 1, 'h55, 0);
    cyc("t4_after", 0, 0, 0, 0, 0);

    // Replace on partial and full stack
    cyc("t5_seed", 1, 0, 0, 'h11, 0);
    cyc("t5_repl", 1, 1, 0, 'h22, 0);
    chk("t5_new_top", 32'(bus.ret_addr), 'h22);
    for (int i = 1; i < DEPTH; i++) cyc("t5_fill", 1, 0, 0, 'h200 + i, 0);
    cyc("t5_repl_full", 1, 1, 0, 'h333, 0);
    cyc("t5_chk", 0, 0, 0, 0, 0);
    cyc("t5_repl_empty_prep", 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc("t5_drain", 0, 1, 0, 0, 0);
    cyc("t5_repl_empty", 1, 1, 0, 'h44, 0);
    cyc("t5_done", 0, 1, 0, 0, 0);

    // Randomized phases alternating fill-bias and drain-bias
    for (int i = 0; i < 400; i++) begin
      bit p, q, s, c;
      int unsigned bias;
      bias = ((i / 40) % 2 == 0) ? 70 : 30;
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < 100 - bias);
      s = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 15) == 0);
      cyc("rand", p, q, s, $urandom & 32'h7FFFF, c);
    end

    // Async reset between edges with five entries and both flags set
    cyc("t6_clr", 0, 0, 0, 0, 1);
    while (stk.size() > 0) cyc("t6_drain", 0, 1, 0, 0, 0);
    cyc("t6_unf", 0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc("t6_fill", 1, 0, 0, 'h300 + i, 0);
    cyc("t6_ovf", 1, 0, 0, 'h3FF, 0);
    for (int i = 0; i < 3; i++) cyc("t6_pop", 0, 1, 0, 0, 0);
    bus.push = 0; bus.pop = 0; bus.err_clr = 0;
    #1;
    chk("t6_pre_count", 32'(bus.count), 5);
    #1;
    rst_n = 1'b0;
    #1;
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
    chk("t6_async_count", 32'(bus.count), 0);
    chk("t6_async_empty", 32'(bus.empty), 1);
    chk("t6_async_ovf", 32'(bus.ovf), 0);
    chk("t6_async_unf", 32'(bus.unf), 0);
    chk("t6_async_ret", 32'(bus.ret_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("t6_post", 1, 0, 0, 'h66, 0);
    cyc("t6_post2", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
